// File: rtl/encoder_8b10b.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | encoder_8b10b : multi-octet 8B/10B encoder, RD chained MSB->LSB, 1 cycle |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module encoder_8b10b #(
  parameter int DATA_BYTES    = 2,
  parameter int PIPELINE_BITS = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_compliance,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [DATA_BYTES*8-1:0]    i_data,
  input  logic [DATA_BYTES-1:0]      i_datak,
  input  logic [PIPELINE_BITS-1:0]   i_pipeline,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [DATA_BYTES*10-1:0]   o_data10,
  output logic [DATA_BYTES-1:0]      o_kerr,
  output logic [PIPELINE_BITS-1:0]   o_pipeline
);

  localparam logic C_RD_NEG = 1'b0;

  // Returns {rd_out, kerr, symbol}; rd = 1 means positive running disparity.
  function automatic logic [11:0] enc_byte(input logic [7:0] b, input logic k, input logic rd);
    logic [4:0] x;
    logic [2:0] y;
    logic       k_ok;
    logic       u6;
    logic [5:0] c6;
    logic       rd6;
    logic       u4;
    logic [3:0] c4;
    logic       a7;
    logic       inv4;
    logic [9:0] sym;
    x    = b[4:0];
    y    = b[7:5];
    k_ok = k && ((x == 5'd28) ||
                 ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30))));
    // 6b codes in abcdei order, RD- form; leading bit marks unbalanced codes
    {u6, c6} = 7'b0_000000;
    case (x)
      5'd0:  {u6, c6} = 7'b1_100111;
      5'd1:  {u6, c6} = 7'b1_011101;
      5'd2:  {u6, c6} = 7'b1_101101;
      5'd3:  {u6, c6} = 7'b0_110001;
      5'd4:  {u6, c6} = 7'b1_110101;
      5'd5:  {u6, c6} = 7'b0_101001;
      5'd6:  {u6, c6} = 7'b0_011001;
      5'd7:  {u6, c6} = 7'b0_111000;
      5'd8:  {u6, c6} = 7'b1_111001;
      5'd9:  {u6, c6} = 7'b0_100101;
      5'd10: {u6, c6} = 7'b0_010101;
      5'd11: {u6, c6} = 7'b0_110100;
      5'd12: {u6, c6} = 7'b0_001101;
      5'd13: {u6, c6} = 7'b0_101100;
      5'd14: {u6, c6} = 7'b0_011100;
      5'd15: {u6, c6} = 7'b1_010111;
      5'd16: {u6, c6} = 7'b1_011011;
      5'd17: {u6, c6} = 7'b0_100011;
      5'd18: {u6, c6} = 7'b0_010011;
      5'd19: {u6, c6} = 7'b0_110010;
      5'd20: {u6, c6} = 7'b0_001011;
      5'd21: {u6, c6} = 7'b0_101010;
      5'd22: {u6, c6} = 7'b0_011010;
      5'd23: {u6, c6} = 7'b1_111010;
      5'd24: {u6, c6} = 7'b1_110011;
      5'd25: {u6, c6} = 7'b0_100110;
      5'd26: {u6, c6} = 7'b0_010110;
      5'd27: {u6, c6} = 7'b1_110110;
      5'd28: {u6, c6} = 7'b0_001110;
      5'd29: {u6, c6} = 7'b1_101110;
      5'd30: {u6, c6} = 7'b1_011110;
      5'd31: {u6, c6} = 7'b1_101011;
    endcase
    if (k_ok && (x == 5'd28)) begin
      {u6, c6} = 7'b1_001111;
    end
    // D.7 is balanced but still has distinct RD+/RD- forms
    if ((u6 || (x == 5'd7)) && rd) begin
      c6 = ~c6;
    end
    rd6 = u6 ? ~rd : rd;

    a7 = k_ok ||
         (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
         ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
    {u4, c4} = 5'b0_0000;
    case (y)
      3'd0: {u4, c4} = 5'b1_1011;
      3'd1: {u4, c4} = 5'b0_1001;
      3'd2: {u4, c4} = 5'b0_0101;
      3'd3: {u4, c4} = 5'b0_1100;
      3'd4: {u4, c4} = 5'b1_1101;
      3'd5: {u4, c4} = 5'b0_1010;
      3'd6: {u4, c4} = 5'b0_0110;
      3'd7: {u4, c4} = a7 ? 5'b1_0111 : 5'b1_1110;
    endcase
    // K.x.1/2/5/6 use the inverse of the D form for a given boundary RD
    if (u4 || (y == 3'd3)) begin
      inv4 = rd6;
    end else begin
      inv4 = k_ok && ((y == 3'd1) || (y == 3'd2) || (y == 3'd5) || (y == 3'd6)) && !rd6;
    end
    if (inv4) begin
      c4 = ~c4;
    end

    sym = '0;
    for (int i = 0; i < 6; i++) begin
      sym[i] = c6[5-i];
    end
    for (int i = 0; i < 4; i++) begin
      sym[6+i] = c4[3-i];
    end
    return {(u4 ? ~rd6 : rd6), (k && !k_ok), sym};
  endfunction

  logic                      valid_q,   valid_d;
  logic [DATA_BYTES*10-1:0]  data_q,    data_d;
  logic [DATA_BYTES-1:0]     kerr_q,    kerr_d;
  logic [PIPELINE_BITS-1:0]  pipe_q,    pipe_d;
  logic                      rd_q,      rd_d;

  logic [DATA_BYTES:0]       w_rd;
  logic [DATA_BYTES*10-1:0]  w_sym;
  logic [DATA_BYTES-1:0]     w_kerr;
  logic                      w_accept;

  assign w_rd[DATA_BYTES] = i_compliance ? C_RD_NEG : rd_q;

  for (genvar n = 0; n < DATA_BYTES; n++) begin : g_byte
    assign {w_rd[n], w_kerr[n], w_sym[n*10+:10]} = enc_byte(i_data[n*8+:8], i_datak[n], w_rd[n+1]);
  end

  assign o_ready  = !valid_q || i_ready;
  assign w_accept = i_valid && o_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    kerr_d  = kerr_q;
    pipe_d  = pipe_q;
    rd_d    = rd_q;
    if (w_accept) begin
      valid_d = 1'b1;
      data_d  = w_sym;
      kerr_d  = w_kerr;
      pipe_d  = i_pipeline;
      rd_d    = w_rd[0];
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      kerr_q  <= '0;
      pipe_q  <= '0;
      rd_q    <= C_RD_NEG;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      kerr_q  <= kerr_d;
      pipe_q  <= pipe_d;
      rd_q    <= rd_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_data10   = data_q;
  assign o_kerr     = kerr_q;
  assign o_pipeline = pipe_q;

endmodule

`default_nettype wire
